req_ack_responder: RTL



---
 rtl/req_ack_pkg.sv | 15 +
 rtl/req_ack_responder_sat_counter.sv | 36 +++
 rtl/req_ack_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types for the request/acknowledge responder.
// The state enum is exported on a debug port; pend_w sizes the backlog count.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALLED = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int pend_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/req_ack_responder_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count holds once it reaches MAX.
module sat_counter #(
  parameter int            W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: one registered ack per request,
// backlogged under stall, with sticky overflow/timeout flags.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 16,
  localparam int PW       = pend_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             stall,
  input  logic             clr_err,
  output logic             b,
  output logic [PW-1:0]    pend_cnt,
  output logic             busy,
  output logic             overflow,
  output logic             timeout,
  output logic [CNT_W-1:0] ack_total,
  output state_t           state
);

  localparam int EW = $clog2(DEPTH + 2);
  localparam int SW = $clog2(MAX_STALL + 2);

  logic          b_q, b_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;
  state_t        state_q, state_d;

  logic [EW-1:0] e;
  logic          ovf_ev;
  logic          tmo_ev;
  logic          stall_inc;
  logic          stall_clr;
  logic [SW-1:0] stall_cnt;

  sat_counter #(
    .W   (SW),
    .MAX (SW'(MAX_STALL + 1))
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (stall_clr),
    .q     (stall_cnt)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ('1)
  ) u_ack_total (
    .clk   (clk),
    .reset (reset),
    .inc   (b_d),
    .clr   (1'b0),
    .q     (ack_total)
  );

  always_comb begin
    e         = EW'(pend_q) + EW'(a);
    b_d       = 1'b0;
    pend_d    = pend_q;
    ovf_ev    = 1'b0;
    stall_inc = stall && (pend_q != '0);
    stall_clr = !stall_inc;
    // timeout fires only on the transition into the saturated count
    tmo_ev    = stall_inc && (stall_cnt == SW'(MAX_STALL));

    if (!stall) begin
      if (e != '0) begin
        b_d    = 1'b1;
        pend_d = PW'(e - EW'(1));
      end
    end else if (e > EW'(DEPTH)) begin
      pend_d = PW'(DEPTH);
      ovf_ev = 1'b1;
    end else begin
      pend_d = PW'(e);
    end

    ovf_d = (ovf_q && !clr_err) || ovf_ev;
    tmo_d = (tmo_q && !clr_err) || tmo_ev;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (stall && a) state_d = STALLED;
      end
      STALLED: begin
        if (pend_d == '0)  state_d = IDLE;
        else if (!stall)   state_d = DRAIN;
      end
      DRAIN: begin
        if (pend_d == '0)  state_d = IDLE;
        else if (stall)    state_d = STALLED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_q     <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      b_q     <= b_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
    end
  end

  assign b        = b_q;
  assign pend_cnt = pend_q;
  assign busy     = (pend_q != '0);
  assign overflow = ovf_q;
  assign timeout  = tmo_q;
  assign state    = state_q;

endmodule
